// File: rtl/egress_sched.sv
// egress_sched: two-class (TS/BE) packet-granular egress scheduler.
// Drains per-class data/info FIFO pairs onto one packet port. TS has strict
// priority, packets with val[15]=0 are discarded, and downstream almost-full
// (usedw[9]) is only honoured when a new packet is about to be granted.
// Optional BE starvation guard: define EGR_BE_STARVE_GUARD_EN.
module egress_sched #(
  parameter int CNT_W        = 16,
  parameter int TS_BURST_MAX = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic [35:0]      i_ts_data_q,
  output logic             o_ts_data_rd,
  input  logic [15:0]      i_ts_info_q,
  input  logic             i_ts_info_empty,
  output logic             o_ts_info_rd,
  input  logic [35:0]      i_be_data_q,
  output logic             o_be_data_rd,
  input  logic [15:0]      i_be_info_q,
  input  logic             i_be_info_empty,
  output logic             o_be_info_rd,
  output logic [35:0]      o_pkt_data,
  output logic             o_pkt_data_en,
  output logic [15:0]      o_pkt_val,
  output logic             o_pkt_val_en,
  input  logic [9:0]       i_pkt_data_usedw,
  output logic [CNT_W-1:0] o_ts_pkt_cnt,
  output logic [CNT_W-1:0] o_be_pkt_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TS_SEND = 2'd1;
  localparam logic [1:0] ST_BE_SEND = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_drop_cls;      // 0: dropping from TS, 1: dropping from BE
  logic [35:0]      r_pkt_data;
  logic             r_pkt_data_en;
  logic [15:0]      r_pkt_val;
  logic             r_pkt_val_en;
  logic [CNT_W-1:0] r_ts_cnt;
  logic [CNT_W-1:0] r_be_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_af;
  logic             w_be_ok;
  logic             w_guard_be;
  logic             w_pick_be;
  logic [15:0]      w_sel_info;
  logic             w_sel_nonempty;
  logic             w_grant;
  logic             w_popping;
  logic             w_pop_cls;
  logic [35:0]      w_pop_word;
  logic             w_pop_tail;
  logic             w_unused_bits;

  assign w_af    = i_pkt_data_usedw[9];
  // BE can make progress right now: it is either a drop or the port has room.
  assign w_be_ok = !i_be_info_empty && (!i_be_info_q[15] || !w_af);

`ifdef EGR_BE_STARVE_GUARD_EN
  localparam int BURST_W = $clog2(TS_BURST_MAX + 1);
  logic [BURST_W-1:0] r_burst;

  assign w_guard_be = (r_burst >= BURST_W'(TS_BURST_MAX)) && w_be_ok;

  // Count consecutive TS grants made while BE was waiting; cleared by BE grants or an empty BE queue.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_burst <= {BURST_W{1'b0}};
    end else if (w_grant) begin
      if (w_pick_be || i_be_info_empty) begin
        r_burst <= {BURST_W{1'b0}};
      end else if (r_burst < BURST_W'(TS_BURST_MAX)) begin
        r_burst <= r_burst + BURST_W'(1);
      end else begin
        r_burst <= r_burst;
      end
    end else begin
      r_burst <= r_burst;
    end
  end
`else
  logic w_unused_burst;
  assign w_guard_be     = 1'b0;
  assign w_unused_burst = ^TS_BURST_MAX;
`endif

  // Arbitration: TS first unless the guard hands this decision to BE.
  assign w_pick_be      = w_guard_be || i_ts_info_empty;
  assign w_sel_info     = w_pick_be ? i_be_info_q : i_ts_info_q;
  assign w_sel_nonempty = w_pick_be ? !i_be_info_empty : !i_ts_info_empty;
  // Drops never wait for the port; valid packets wait while almost-full.
  assign w_grant = (r_state == ST_IDLE) && w_sel_nonempty &&
                   (!w_sel_info[15] || !w_af) && !i_sys_rst;

  assign w_popping  = (r_state != ST_IDLE) && !i_sys_rst;
  assign w_pop_cls  = (r_state == ST_BE_SEND) || ((r_state == ST_DROP) && r_drop_cls);
  assign w_pop_word = w_pop_cls ? i_be_data_q : i_ts_data_q;
  assign w_pop_tail = w_pop_word[34];

  assign w_unused_bits = ^{i_ts_info_q[14], i_be_info_q[14], i_pkt_data_usedw[8:0]};

  // FIFO pops and next-state decode; pops are combinational so the head word is consumed this cycle.
  always_comb begin
    w_state_nxt  = r_state;
    o_ts_info_rd = 1'b0;
    o_be_info_rd = 1'b0;
    o_ts_data_rd = 1'b0;
    o_be_data_rd = 1'b0;
    if (w_grant) begin
      if (w_pick_be) begin
        o_be_info_rd = 1'b1;
      end else begin
        o_ts_info_rd = 1'b1;
      end
    end else begin
      o_ts_info_rd = 1'b0;
      o_be_info_rd = 1'b0;
    end
    if (w_popping) begin
      if (w_pop_cls) begin
        o_be_data_rd = 1'b1;
      end else begin
        o_ts_data_rd = 1'b1;
      end
    end else begin
      o_ts_data_rd = 1'b0;
      o_be_data_rd = 1'b0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          if (!w_sel_info[15]) begin
            w_state_nxt = ST_DROP;
          end else if (w_pick_be) begin
            w_state_nxt = ST_BE_SEND;
          end else begin
            w_state_nxt = ST_TS_SEND;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TS_SEND, ST_BE_SEND, ST_DROP: begin
        if (w_pop_tail) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, registered output port and wrapping packet/drop counters.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state       <= ST_IDLE;
      r_drop_cls    <= 1'b0;
      r_pkt_data    <= 36'd0;
      r_pkt_data_en <= 1'b0;
      r_pkt_val     <= 16'd0;
      r_pkt_val_en  <= 1'b0;
      r_ts_cnt      <= {CNT_W{1'b0}};
      r_be_cnt      <= {CNT_W{1'b0}};
      r_drop_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_pkt_data_en <= 1'b0;
      r_pkt_val_en  <= 1'b0;
      if (w_grant) begin
        r_drop_cls <= w_pick_be;
        if (w_sel_info[15]) begin
          r_pkt_val <= {1'b1, 1'b0, w_sel_info[13:0]};
        end
      end
      if ((r_state == ST_TS_SEND) || (r_state == ST_BE_SEND)) begin
        r_pkt_data    <= w_pop_word;
        r_pkt_data_en <= 1'b1;
        if (w_pop_tail) begin
          r_pkt_val_en <= 1'b1;
          if (r_state == ST_BE_SEND) begin
            r_be_cnt <= r_be_cnt + CNT_W'(1);
          end else begin
            r_ts_cnt <= r_ts_cnt + CNT_W'(1);
          end
        end
      end else if ((r_state == ST_DROP) && w_pop_tail) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pkt_data    = r_pkt_data;
  assign o_pkt_data_en = r_pkt_data_en;
  assign o_pkt_val     = r_pkt_val;
  assign o_pkt_val_en  = r_pkt_val_en;
  assign o_ts_pkt_cnt  = r_ts_cnt;
  assign o_be_pkt_cnt  = r_be_cnt;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_egress_sched.sv
// tb_egress_sched: randomized + directed bench for egress_sched with a
// packet-level reference model (queues of whole packets, arbitration rules).
module tb_egress_sched;
  localparam int CNT_W    = 4;   // small so counter wrap is reached
  localparam int TB_BURST = 2;
`ifdef EGR_BE_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [35:0] ts_data_q = 36'd0, be_data_q = 36'd0;
  logic [15:0] ts_info_q = 16'd0, be_info_q = 16'd0;
  logic ts_info_empty = 1'b1, be_info_empty = 1'b1;
  logic [9:0] usedw = 10'd0;
  logic ts_data_rd, be_data_rd, ts_info_rd, be_info_rd;
  logic [35:0] pkt_data;
  logic pkt_data_en, pkt_val_en;
  logic [15:0] pkt_val;
  logic [CNT_W-1:0] ts_cnt, be_cnt, drop_cnt;

  egress_sched #(.CNT_W(CNT_W), .TS_BURST_MAX(TB_BURST)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_ts_data_q(ts_data_q), .o_ts_data_rd(ts_data_rd),
    .i_ts_info_q(ts_info_q), .i_ts_info_empty(ts_info_empty), .o_ts_info_rd(ts_info_rd),
    .i_be_data_q(be_data_q), .o_be_data_rd(be_data_rd),
    .i_be_info_q(be_info_q), .i_be_info_empty(be_info_empty), .o_be_info_rd(be_info_rd),
    .o_pkt_data(pkt_data), .o_pkt_data_en(pkt_data_en),
    .o_pkt_val(pkt_val), .o_pkt_val_en(pkt_val_en),
    .i_pkt_data_usedw(usedw),
    .o_ts_pkt_cnt(ts_cnt), .o_be_pkt_cnt(be_cnt), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO models (show-ahead) feeding the DUT.
  logic [35:0] ts_dq[$], be_dq[$];
  logic [15:0] ts_iq[$], be_iq[$];
  int cyc = 0;
  int ts_pops = 0, be_pops = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ts_dq.delete(); be_dq.delete(); ts_iq.delete(); be_iq.delete();
    end else begin
      if (ts_data_rd && ts_dq.size() > 0) begin void'(ts_dq.pop_front()); ts_pops <= ts_pops + 1; end
      if (be_data_rd && be_dq.size() > 0) begin void'(be_dq.pop_front()); be_pops <= be_pops + 1; end
      if (ts_info_rd && ts_iq.size() > 0) void'(ts_iq.pop_front());
      if (be_info_rd && be_iq.size() > 0) void'(be_iq.pop_front());
    end
    ts_data_q     <= (ts_dq.size() > 0) ? ts_dq[0] : 36'd0;
    be_data_q     <= (be_dq.size() > 0) ? be_dq[0] : 36'd0;
    ts_info_q     <= (ts_iq.size() > 0) ? ts_iq[0] : 16'd0;
    be_info_q     <= (be_iq.size() > 0) ? be_iq[0] : 16'd0;
    ts_info_empty <= (ts_iq.size() == 0);
    be_info_empty <= (be_iq.size() == 0);
  end

  // Reference model: per-class packet queues, expected output words and grant order.
  typedef struct packed { logic [35:0] d; logic [15:0] v; } ew_t;
  logic [35:0] m_ts_w[$], m_be_w[$];
  logic [15:0] m_ts_v[$], m_be_v[$];
  ew_t exp_q[$];
  bit exp_grant[$], dut_grant[$];
  int gq_cyc[$];
  int m_burst = 0;
  logic [CNT_W-1:0] m_ts_cnt = '0, m_be_cnt = '0, m_drop_cnt = '0;

  task automatic push_pkt(input bit cls, input int nw, input logic [15:0] val);
    logic [35:0] w;
    for (int i = 0; i < nw; i++) begin
      w[35:34] = (i == 0) ? 2'b10 : ((i == nw - 1) ? 2'b01 : 2'b00);
      w[33:32] = 2'($urandom);
      w[31:0]  = $urandom;
      if (cls) begin be_dq.push_back(w); m_be_w.push_back(w); end
      else     begin ts_dq.push_back(w); m_ts_w.push_back(w); end
    end
    if (cls) begin be_iq.push_back(val); m_be_v.push_back(val); end
    else     begin ts_iq.push_back(val); m_ts_v.push_back(val); end
  endtask

  // Order every queued packet by the arbitration rules (all assumed pending together).
  task automatic model_run();
    bit pick_be;
    logic [15:0] v;
    logic [35:0] w;
    while (m_ts_v.size() > 0 || m_be_v.size() > 0) begin
      if (GUARD && m_burst >= TB_BURST && m_be_v.size() > 0) pick_be = 1'b1;
      else pick_be = (m_ts_v.size() == 0);
      exp_grant.push_back(pick_be);
      if (pick_be) m_burst = 0;
      else if (m_be_v.size() == 0) m_burst = 0;
      else m_burst++;
      v = pick_be ? m_be_v.pop_front() : m_ts_v.pop_front();
      do begin
        w = pick_be ? m_be_w.pop_front() : m_ts_w.pop_front();
        if (v[15]) exp_q.push_back({w, 1'b1, 1'b0, v[13:0]});
      end while (!w[34]);
      if (!v[15]) m_drop_cnt++;
      else if (pick_be) m_be_cnt++;
      else m_ts_cnt++;
    end
  endtask

  // Output monitor: words, val, latency, no-gap and single-pop rules.
  bit expect_cont = 1'b0;
  int pkt_start = 0;
  int word_idx = 0;
  always @(negedge clk) begin
    if (rst) begin
      expect_cont = 1'b0;
    end else begin
      if (ts_info_rd || be_info_rd) begin
        check("one_info_rd", 64'(ts_info_rd & be_info_rd), 64'd0);
        dut_grant.push_back(be_info_rd);
        if (be_info_rd ? be_info_q[15] : ts_info_q[15]) gq_cyc.push_back(cyc);
      end
      if (ts_data_rd || be_data_rd) check("one_data_rd", 64'(ts_data_rd & be_data_rd), 64'd0);
      if (expect_cont) check("no_gap", 64'(pkt_data_en), 64'd1);
      if (pkt_data_en) begin
        if (pkt_data[35]) begin
          pkt_start = (gq_cyc.size() > 0) ? gq_cyc.pop_front() : -100;
          word_idx = 0;
          check("lat_first", 64'(cyc - pkt_start), 64'd2);
        end
        word_idx++;
        if (exp_q.size() == 0) begin
          check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        end else begin
          ew_t e;
          e = exp_q.pop_front();
          check("word", 64'(pkt_data), 64'(e.d));
          check("val_en", 64'(pkt_val_en), 64'(e.d[34]));
          if (e.d[34]) begin
            check("val", 64'(pkt_val), 64'(e.v));
            check("lat_tail", 64'(cyc - pkt_start), 64'(word_idx + 1));
          end
        end
      end else if (pkt_val_en) begin
        check("val_en_alone", 64'(pkt_val_en), 64'd0);
      end
      expect_cont = pkt_data_en && !pkt_data[34];
    end
  end

  task automatic drain(input string tag, input bit rand_af);
    int n;
    n = 0;
    while ((ts_iq.size() + be_iq.size() + ts_dq.size() + be_dq.size() + exp_q.size()) > 0 && n < 3000) begin
      @(negedge clk);
      if (rand_af && !GUARD) usedw = 10'($urandom);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 3000), 64'd1);
    usedw = 10'd0;
    repeat (4) @(negedge clk);
    check({tag, "_ngrant"}, 64'(dut_grant.size()), 64'(exp_grant.size()));
    for (int i = 0; i < dut_grant.size() && i < exp_grant.size(); i++)
      check({tag, "_grant_cls"}, 64'(dut_grant[i]), 64'(exp_grant[i]));
    check({tag, "_ts_cnt"}, 64'(ts_cnt), 64'(m_ts_cnt));
    check({tag, "_be_cnt"}, 64'(be_cnt), 64'(m_be_cnt));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop_cnt));
    dut_grant.delete();
    exp_grant.delete();
  endtask

  task automatic wait_data_en(input string tag);
    int n;
    n = 0;
    while (!pkt_data_en && n < 50) begin @(negedge clk); n++; end
    check({tag, "_wait_data_en"}, 64'(pkt_data_en), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, 64'(pkt_data), 64'd0);
    check({tag, "_ctl"}, 64'({pkt_data_en, pkt_val_en, ts_data_rd, be_data_rd, ts_info_rd, be_info_rd}), 64'd0);
    check({tag, "_val"}, 64'(pkt_val), 64'd0);
    check({tag, "_cnt"}, 64'({ts_cnt, be_cnt, drop_cnt}), 64'd0);
  endtask

  initial begin
    int p0;
    int nts, nbe;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // Single TS packet, 4 words
    push_pkt(1'b0, 4, 16'h8040);
    model_run();
    drain("t1", 1'b0);
    check("t1_val_hold", 64'(pkt_val), 64'h8040);

    // TS and BE pending together
    push_pkt(1'b1, 3, 16'h8010);
    push_pkt(1'b0, 5, 16'hC020);
    model_run();
    drain("t2", 1'b0);

    // BE stalled by almost-full, TS arrives and wins
    usedw = 10'h200;
    push_pkt(1'b1, 4, 16'h8004);
    repeat (10) begin
      @(negedge clk);
      check("stall_be", 64'({ts_data_rd, be_data_rd, ts_info_rd, be_info_rd}), 64'd0);
    end
    push_pkt(1'b0, 3, 16'h8003);
    repeat (3) begin
      @(negedge clk);
      check("stall_both", 64'({ts_data_rd, be_data_rd, ts_info_rd, be_info_rd}), 64'd0);
    end
    model_run();
    usedw = 10'd0;
    drain("t3", 1'b0);

    // Dropped packets, with and without almost-full
    p0 = ts_pops;
    push_pkt(1'b0, 3, 16'h0003);
    model_run();
    drain("t4a", 1'b0);
    check("t4a_pops", 64'(ts_pops - p0), 64'd3);
    p0 = be_pops;
    usedw = 10'h200;
    push_pkt(1'b1, 3, 16'h4003);
    model_run();
    repeat (8) @(negedge clk);
    check("t4b_pops_af", 64'(be_pops - p0), 64'd3);
    drain("t4b", 1'b0);

    // Almost-full rising mid-packet must not stall it
    push_pkt(1'b0, 8, 16'h8008);
    model_run();
    wait_data_en("t5");
    usedw = 10'h200;
    repeat (12) @(negedge clk);
    drain("t5", 1'b0);

    // Continuous TS and BE traffic: strict priority or guarded interleave
    for (int i = 0; i < 6; i++) push_pkt(1'b0, 3, 16'h8100 | 16'(i));
    for (int i = 0; i < 3; i++) push_pkt(1'b1, 2, 16'h8200 | 16'(i));
    model_run();
    drain("t6", 1'b0);

    // Randomized rounds with random almost-full
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      nts = $urandom_range(0, 4);
      nbe = $urandom_range(0, 4);
      for (int i = 0; i < nts; i++)
        push_pkt(1'b0, $urandom_range(2, 6), {1'($urandom_range(0, 9) != 0), 1'($urandom), 14'($urandom)});
      for (int i = 0; i < nbe; i++)
        push_pkt(1'b1, $urandom_range(2, 6), {1'($urandom_range(0, 9) != 0), 1'($urandom), 14'($urandom)});
      model_run();
      drain("rnd", 1'b1);
    end

    // Reset in the middle of a packet
    push_pkt(1'b0, 6, 16'h8006);
    model_run();
    wait_data_en("t8");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    exp_q.delete(); gq_cyc.delete(); dut_grant.delete(); exp_grant.delete();
    m_ts_w.delete(); m_be_w.delete(); m_ts_v.delete(); m_be_v.delete();
    m_burst = 0; m_ts_cnt = '0; m_be_cnt = '0; m_drop_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_mid_rst");
    push_pkt(1'b1, 2, 16'h8002);
    model_run();
    drain("t8", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/egress_sched.md
Name: egress_sched

Overview:
- Two-class, packet-granular egress scheduler.
- Drains the TS (time-sensitive) and BE (best-effort) queues that ingress classification fills, and merges them onto one output port using the 36-bit packet-word / 16-bit packet-val format.
- Strict priority to TS. Packets whose val bit[15]=0 are dropped. Downstream almost-full backpressure is honoured at packet boundaries only.
- Sits between the per-class data/info FIFO pairs and the port transmit FIFO.

Parameters:
- CNT_W, 16, width of per-class packet/drop counters (wrap-around).
- TS_BURST_MAX, 8, consecutive TS grants allowed while BE is pending (used only with the optional feature).

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  synchronous reset, active-high
- i_ts_data_q  in  36  TS data FIFO head word (show-ahead); [35:34] 10 head/00 body/01 tail, [33:32] valid bytes, [31:0] data
- o_ts_data_rd  out  1  TS data FIFO pop
- i_ts_info_q  in  16  TS info FIFO head; [15] frame valid, [14] class flag, [13:0] length
- i_ts_info_empty  in  1  TS info FIFO empty
- o_ts_info_rd  out  1  TS info FIFO pop
- i_be_data_q  in  36  BE data head word
- o_be_data_rd  out  1  BE data FIFO pop
- i_be_info_q  in  16  BE info head
- i_be_info_empty  in  1  BE info FIFO empty
- o_be_info_rd  out  1  BE info FIFO pop
- o_pkt_data  out  36  merged packet word
- o_pkt_data_en  out  1  word enable
- o_pkt_val  out  16  {valid, 0, length[13:0]}
- o_pkt_val_en  out  1  val enable, asserted with the tail word
- i_pkt_data_usedw  in  10  downstream FIFO used words; bit[9] = almost-full
- o_ts_pkt_cnt  out  CNT_W  TS packets forwarded
- o_be_pkt_cnt  out  CNT_W  BE packets forwarded
- o_drop_cnt  out  CNT_W  packets dropped (val[15]=0)

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Store-and-forward contract: an info entry is written only after its full packet is in the data FIFO. Data is therefore never empty while the block is in SEND or DROP.
- States: IDLE, TS_SEND, BE_SEND, DROP.
- IDLE (one cycle per decision):
  - If TS info is non-empty: TS is the candidate. Otherwise, if BE info is non-empty: BE is the candidate. Otherwise stay in IDLE.
  - Candidate with info[15]=0: pulse its info_rd (combinational, this cycle) and go to DROP. This happens regardless of almost-full.
  - Candidate with info[15]=1 and i_pkt_data_usedw[9]=0: pulse its info_rd, latch o_pkt_val={1,0,info[13:0]}, and go to that class's SEND state.
  - Candidate with info[15]=1 and almost-full=1: stay in IDLE, pop nothing. Re-arbitrate every cycle; a newly arrived TS packet preempts a waiting BE packet.
- SEND (class X):
  - The class's data_rd is combinationally 1 every cycle in SEND.
  - Next cycle: o_pkt_data = the popped word, o_pkt_data_en = 1.
  - When the popped word has [34]=1: o_pkt_val_en=1 with that output word, increment the class counter, return to IDLE.
  - Almost-full is ignored mid-packet.
- DROP: pop the data FIFO of the selected class each cycle until a word with [34]=1 is popped, then go to IDLE. No output enables; o_drop_cnt increments once per packet.
- Latency: IDLE grant at cycle 0 → first output word at cycle 2 → tail at cycle L+1 for an L-word packet. Minimum one idle cycle between packets.
- Only one info_rd and at most one data_rd are active per cycle. TS and BE pops are never simultaneous.
- Counters wrap from 2^CNT_W-1 to 0.
- Reset mid-packet: return to IDLE at once and deassert all outputs. FIFOs are reset by the same reset in the parent.

Optional Feature:
- Macro: EGR_BE_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive TS grants made while BE info was non-empty.
  - When it reaches TS_BURST_MAX, the next IDLE decision picks BE first, provided BE info is non-empty; TS is chosen only if BE cannot proceed.
  - The counter clears on any BE grant, or whenever BE info is empty at a TS grant.
- Undefined: pure strict priority; no counter logic is present.

Test Plan:
- Single TS packet, 4 words, val=0x8040, usedw=0 → outputs at cycles 2..5, o_pkt_val=0x8040 with val_en on the tail word, o_ts_pkt_cnt=1.
- TS and BE both pending at the same cycle → the full TS packet is sent first, then BE; o_ts_info_rd and o_be_info_rd never high together.
- BE packet waiting with usedw=0x200 for 10 cycles, then a TS packet arrives, then usedw=0 → TS is sent first; no pops during the stall.
- Info val[15]=0, 3-word packet → 3 data pops, no data_en, o_drop_cnt=1. Repeat with usedw[9]=1 → still dropped.
- usedw rises to 0x200 mid-packet → packet completes without gaps.
- With EGR_BE_STARVE_GUARD_EN and TS_BURST_MAX=2, continuous TS and BE traffic → grant order TS,TS,BE,TS,TS,BE. Without the macro: all TS, BE starved.
